mem_stage_ctrl: RTL and testbench

Sequences MEM-stage loads and stores against a multicycle data memory/cache port using a req/ready handshake. While an access is outstanding it freezes the pipeline, including the EX/MEM and MEM/WB registers. It generates byte enables and store-data lane replication, and sign- or zero-extends load data before it enters the MEM/WB register. It flags misaligned or illegal accesses and memory timeouts.

---
 rtl/mem_stage_ctrl_pkg.sv | 36 +++
 rtl/mem_stage_ctrl_if.sv | 35 +++
 rtl/mem_stage_ctrl_lane_fmt.sv | 57 +++++
 rtl/mem_stage_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory controller: funct3 size codes,
// FSM state encoding and the access legality rule.
package mem_stage_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Unsigned variants exist only for loads; alignment follows the access size.
    function automatic logic access_legal(input logic [2:0] f3,
                                          input logic [1:0] lo,
                                          input logic       is_store);
        logic code_ok;
        logic aligned;
        case (f3)
            F3_B, F3_H, F3_W: code_ok = 1'b1;
            F3_BU, F3_HU:     code_ok = ~is_store;
            default:          code_ok = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   aligned = ~lo[0];
            2'b10:   aligned = (lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return code_ok & aligned;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the MEM-stage controller and the
// memory/cache port.
interface mem_stage_ctrl_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_byte_en;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_byte_en,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_byte_en,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_lane_fmt.sv
// Combinational lane logic: byte enables and store replication for the
// request side, lane extraction and sign/zero extension for the load side.
module mem_lane_fmt
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      st_funct3_i,
    input  logic [1:0]      st_addr_lo_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [3:0]      byte_en_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] load_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        byte_en_o = '0;
        wdata_o   = store_data_i;
        case (st_funct3_i[1:0])
            2'b00: begin
                byte_en_o = 4'b0001 << st_addr_lo_i;
                wdata_o   = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                byte_en_o = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o   = {2{store_data_i[15:0]}};
            end
            2'b10:   byte_en_o = 4'b1111;
            default: byte_en_o = '0;
        endcase
    end

    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    load_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_H:    load_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, ld_byte};
            F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, ld_half};
            F3_W:    load_data_o = rdata_i;
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store sequencer: issues one registered request per memory
// instruction, freezes the pipeline until completion, and reports faults.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    mem_stage_ctrl_if.master dmem,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            misalign_fault,
    output logic            bus_error
);

    state_e                state_q, state_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            lo_q, lo_d;
    logic [XLEN-1:0]       ld_q, ld_d;
    logic                  fault_q, fault_d;
    logic                  berr_q, berr_d;

    logic                  mem_access;
    logic                  legal;
    logic [3:0]            fmt_be;
    logic [XLEN-1:0]       fmt_wdata;
    logic [XLEN-1:0]       fmt_load;

    mem_lane_fmt #(.XLEN(XLEN)) u_fmt (
        .st_funct3_i  (funct3),
        .st_addr_lo_i (addr[1:0]),
        .store_data_i (store_data),
        .byte_en_o    (fmt_be),
        .wdata_o      (fmt_wdata),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (lo_q),
        .rdata_i      (dmem.dmem_rdata),
        .load_data_o  (fmt_load)
    );

    // A simultaneous read and write is treated as a store.
    assign mem_access = mem_read | mem_write;
    assign legal      = access_legal(funct3, addr[1:0], mem_write);
    assign stall      = ((state_q == ST_IDLE) & mem_access & legal) | (state_q == ST_ACCESS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        ld_d    = ld_q;
        fault_d = 1'b0;
        berr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_access) begin
                    if (legal) begin
                        state_d = ST_ACCESS;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        be_d    = fmt_be;
                        addr_d  = {addr[XLEN-1:2], 2'b00};
                        wdata_d = fmt_wdata;
                        f3_d    = funct3;
                        lo_d    = addr[1:0];
                    end else begin
                        fault_d = 1'b1;
                        ld_d    = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmem.dmem_ready) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    cnt_d   = '0;
                    if (!we_q) ld_d = fmt_load;
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    cnt_d   = '0;
                    berr_d  = 1'b1;
                    ld_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            ld_q    <= '0;
            fault_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            ld_q    <= ld_d;
            fault_q <= fault_d;
            berr_q  <= berr_d;
        end
    end

    assign dmem.dmem_req     = req_q;
    assign dmem.dmem_we      = we_q;
    assign dmem.dmem_byte_en = be_q;
    assign dmem.dmem_addr    = addr_q;
    assign dmem.dmem_wdata   = wdata_q;
    assign load_data         = ld_q;
    assign misalign_fault    = fault_q;
    assign bus_error         = berr_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a transaction-level expectation model
// checked on every cycle, plus literal spot checks.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        misalign_fault, bus_error;

    mem_stage_ctrl_if #(.XLEN(32)) dmem ();

    mem_stage_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .dmem           (dmem),
        .stall          (stall),
        .load_data      (load_data),
        .misalign_fault (misalign_fault),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_fault, exp_berr, exp_we, exp_chk_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [31:0] mdl_ld = '0;

    int          req_cnt, stall_cnt;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;
    logic        last_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("dmem_req", 32'(dmem.dmem_req), 32'(exp_req));
            chk("misalign_fault", 32'(misalign_fault), 32'(exp_fault));
            chk("bus_error", 32'(bus_error), 32'(exp_berr));
            chk("load_data", load_data, exp_ld);
            if (exp_req) begin
                chk("dmem_we", 32'(dmem.dmem_we), 32'(exp_we));
                chk("dmem_byte_en", 32'(dmem.dmem_byte_en), 32'(exp_be));
                chk("dmem_addr", dmem.dmem_addr, exp_addr);
                if (exp_chk_wdata) chk("dmem_wdata", dmem.dmem_wdata, exp_wdata);
            end
        end
    end

    function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit code_ok;
        int n;
        if (st) code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        n = 1 << f3[1:0];
        return code_ok && ((a % n) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = 1 << f3[1:0];
        return 4'(((1 << n) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'd0:    return 32'(sd[7:0]) * 32'h0101_0101;
            2'd1:    return 32'(sd[15:0]) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0]        s;
        logic signed [31:0] v;
        s = rd >> (8 * a[1:0]);
        case (f3)
            3'd0:    v = $signed(s[7:0]);
            3'd1:    v = $signed(s[15:0]);
            3'd4:    v = s & 32'h0000_00FF;
            3'd5:    v = s & 32'h0000_FFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic cyc();
        @(negedge clk);
        req_cnt   += int'(dmem.dmem_req);
        stall_cnt += int'(stall);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc();
        mem_read = 1'b0; mem_write = 1'b0;
        dmem.dmem_ready = rdy; dmem.dmem_rdata = $urandom;
        exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0; exp_berr = 1'b0; exp_ld = mdl_ld;
    endtask

    // dly < 0 (or >= TO) means the memory never answers.
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int dly, input logic [31:0] rdv);
        bit st, lg, tmo;
        st = wr;
        lg = m_legal(st, f3, a);
        tmo = 1'b0;
        cyc();
        req_cnt = 0; stall_cnt = 0;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        dmem.dmem_ready = 1'b0;
        exp_stall = lg; exp_req = 1'b0; exp_fault = 1'b0; exp_berr = 1'b0; exp_ld = mdl_ld;
        if (!lg) begin
            cyc();
            mem_read = 1'b0; mem_write = 1'b0;
            exp_stall = 1'b0; exp_fault = 1'b1;
            mdl_ld = '0; exp_ld = '0;
            return;
        end
        exp_we = st; exp_be = m_be(f3, a); exp_addr = {a[31:2], 2'b00};
        exp_wdata = m_wdata(f3, sd); exp_chk_wdata = st;
        for (int i = 0; i < TO; i++) begin
            cyc();
            exp_req = 1'b1; exp_stall = 1'b1;
            if (i == 0) begin
                last_be = dmem.dmem_byte_en; last_wdata = dmem.dmem_wdata; last_we = dmem.dmem_we;
            end
            if (dly == i) begin
                dmem.dmem_ready = 1'b1; dmem.dmem_rdata = rdv;
                break;
            end
            dmem.dmem_ready = 1'b0; dmem.dmem_rdata = $urandom;
            if (i == TO - 1) tmo = 1'b1;
        end
        cyc();
        dmem.dmem_ready = 1'b0; dmem.dmem_rdata = $urandom;
        exp_req = 1'b0; exp_stall = 1'b0; exp_berr = tmo;
        if (tmo) mdl_ld = '0;
        else if (!st) mdl_ld = m_load(f3, a, rdv);
        exp_ld = mdl_ld;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        addr = '0; store_data = '0; dmem.dmem_ready = 1'b0; dmem.dmem_rdata = '0;
        exp_stall = 0; exp_req = 0; exp_fault = 0; exp_berr = 0; exp_we = 0;
        exp_chk_wdata = 0; exp_be = '0; exp_addr = '0; exp_wdata = '0; exp_ld = '0;
        req_cnt = 0; stall_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_req", 32'(dmem.dmem_req), 32'd0);
        chk("rst_we", 32'(dmem.dmem_we), 32'd0);
        chk("rst_be", 32'(dmem.dmem_byte_en), 32'd0);
        chk("rst_addr", dmem.dmem_addr, 32'd0);
        chk("rst_wdata", dmem.dmem_wdata, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flags", {30'd0, misalign_fault, bus_error}, 32'd0);
        chk_en = 1'b1;
        idle(1'b1);

        do_op(1, 0, F3_W, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        chk("lw_load_lit", load_data, 32'hDEADBEEF);
        chk("lw_be_lit", 32'(last_be), 32'hF);
        chk("lw_stall_cycles", stall_cnt, 2);
        chk("lw_req_cycles", req_cnt, 1);

        do_op(1, 0, F3_B, 32'h103, 32'h0, 0, 32'h80112233);
        chk("lb_load_lit", load_data, 32'hFFFFFF80);
        chk("lb_be_lit", 32'(last_be), 32'h8);
        do_op(1, 0, F3_BU, 32'h103, 32'h0, 1, 32'h80112233);
        chk("lbu_load_lit", load_data, 32'h00000080);
        do_op(1, 0, F3_H, 32'h102, 32'h0, 2, 32'h80112233);
        chk("lh_load_lit", load_data, 32'hFFFF8011);
        chk("lh_req_cycles", req_cnt, 3);
        do_op(1, 0, F3_HU, 32'h102, 32'h0, 0, 32'h80112233);
        do_op(1, 0, F3_H, 32'h100, 32'h0, 0, 32'h80112233);
        do_op(1, 0, F3_B, 32'h101, 32'h0, 0, 32'h80112233);
        idle(1'b1);

        do_op(0, 1, F3_B, 32'h201, 32'h000000A5, 0, 32'h0);
        chk("sb_we_lit", 32'(last_we), 32'd1);
        chk("sb_be_lit", 32'(last_be), 32'h2);
        chk("sb_wdata_lit", last_wdata, 32'hA5A5A5A5);
        chk("sb_load_held_lit", load_data, 32'h00000022);
        do_op(1, 1, F3_H, 32'h202, 32'h00001234, 1, 32'h0);
        chk("sh_be_lit", 32'(last_be), 32'hC);
        chk("sh_wdata_lit", last_wdata, 32'h12341234);
        do_op(0, 1, F3_W, 32'h208, 32'h87654321, 2, 32'h0);

        do_op(1, 0, F3_W, 32'h102, 32'h0, 0, 32'h0);
        chk("lw_mis_fault_lit", 32'(misalign_fault), 32'd1);
        chk("lw_mis_req_cycles", req_cnt, 0);
        idle(1'b0);
        do_op(0, 1, 3'b011, 32'h200, 32'h55, 0, 32'h0);
        chk("st_bad_f3_fault_lit", 32'(misalign_fault), 32'd1);
        idle(1'b0);
        do_op(1, 0, F3_HU, 32'h101, 32'h0, 0, 32'h0);
        do_op(1, 0, 3'b110, 32'h100, 32'h0, 0, 32'h0);
        do_op(0, 1, F3_BU, 32'h100, 32'h0, 0, 32'h0);
        idle(1'b0);

        do_op(1, 0, F3_W, 32'h100, 32'h0, 0, 32'h13579BDF);
        do_op(1, 0, F3_W, 32'h400, 32'h0, -1, 32'h0);
        chk("tmo_req_cycles", req_cnt, TO);
        chk("tmo_berr_lit", 32'(bus_error), 32'd1);
        chk("tmo_load_lit", load_data, 32'd0);
        do_op(1, 0, F3_W, 32'h404, 32'h0, 0, 32'h11223344);
        chk("b2b_load_lit", load_data, 32'h11223344);

        cyc();
        mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h300;
        dmem.dmem_ready = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_fault = 1'b0; exp_berr = 1'b0; exp_ld = mdl_ld;
        exp_we = 1'b0; exp_be = 4'hF; exp_addr = 32'h300; exp_chk_wdata = 1'b0;
        cyc(); exp_req = 1'b1;
        cyc();
        cyc(); reset = 1'b1;
        cyc();
        reset = 1'b0; mem_read = 1'b0;
        dmem.dmem_ready = 1'b1; dmem.dmem_rdata = 32'hCAFEF00D;
        exp_req = 1'b0; exp_stall = 1'b0; mdl_ld = '0; exp_ld = '0;
        chk("rst_mid_req_lit", 32'(dmem.dmem_req), 32'd0);
        cyc();
        dmem.dmem_ready = 1'b0;
        chk("late_ready_load_lit", load_data, 32'd0);
        do_op(1, 0, F3_W, 32'h304, 32'h0, 2, 32'h0BADF00D);
        chk("post_rst_load_lit", load_data, 32'h0BADF00D);
        idle(1'b0);
        idle(1'b0);
        @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
